hslp_mul_pipe: RTL and testbench



---
 rtl/hslp_pkg.sv | 9 +
 rtl/hslp_mul_pipe_if.sv | 23 ++
 rtl/hslp_qmul.sv | 21 ++
 rtl/hslp_mul_pipe.sv | 73 +++++++
 tb/tb_hslp_mul_pipe.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/hslp_pkg.sv
// Shared constants for the hybrid-split approximate multiplier pipeline.
// Quadrant indices double as bit positions in the per-beat mode word.
package hslp_pkg;
    localparam int MODE_W = 4;
    localparam int QHH    = 3;
    localparam int QHL    = 2;
    localparam int QLH    = 1;
    localparam int QLL    = 0;
endpackage

// File: rtl/hslp_mul_pipe_if.sv
// Operand/result stream bundle: input valid/ready beat plus output valid/ready result.
interface hslp_mul_pipe_if #(parameter int W = 8);
    import hslp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a;
    logic [W-1:0]      in_b;
    logic [MODE_W-1:0] in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [2*W-1:0]    out_prod;
    logic [MODE_W-1:0] out_mode;

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_prod, out_mode
    );
    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_prod, out_mode
    );
endinterface

// File: rtl/hslp_qmul.sv
// Combinational HxH quadrant multiplier; when approx is set, partial-product
// bits landing in columns below TRUNC are dropped with no compensation.
module hslp_qmul #(
    parameter int H     = 4,
    parameter int TRUNC = 3
) (
    input  logic [H-1:0]   x,
    input  logic [H-1:0]   y,
    input  logic           approx,
    output logic [2*H-1:0] prod
);
    always_comb begin
        prod = '0;
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < H; j++) begin
                if (x[i] && y[j] && (!approx || (i + j >= TRUNC)))
                    prod = prod + ((2*H)'(1) << (i + j));
            end
        end
    end
endmodule

// File: rtl/hslp_mul_pipe.sv
// Three-stage WxW approximate multiplier: S1 operands, S2 quadrant products,
// S3 recombined result. Each stage loads when empty or when draining downstream.
module hslp_mul_pipe
    import hslp_pkg::*;
#(
    parameter int W     = 8,
    parameter int TRUNC = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    hslp_mul_pipe_if.slave bus
);
    localparam int H      = W / 2;
    localparam int STAGES = 3;

    logic [STAGES:1]             vld_pipe;
    logic                        s1_en, s2_en, s3_en;
    logic [1:0][H-1:0]           a_h, b_h;
    logic [MODE_W-1:0]           s1_mode, s2_mode;
    logic [3:0][2*H-1:0]         q_comb, s2_q;
    logic [2*H:0]                mid;
    logic [2*W-1:0]              sum;

    // Ready chain runs back from the consumer combinationally.
    assign s3_en        = !vld_pipe[3] || bus.out_ready;
    assign s2_en        = !vld_pipe[2] || s3_en;
    assign s1_en        = !vld_pipe[1] || s2_en;
    assign bus.in_ready = s1_en;
    assign bus.out_valid = vld_pipe[3];

    for (genvar g = 0; g < 4; g++) begin : g_quad
        hslp_qmul #(.H(H), .TRUNC(TRUNC)) u_qmul (
            .x      (a_h[g/2]),
            .y      (b_h[g%2]),
            .approx (s1_mode[g]),
            .prod   (q_comb[g])
        );
    end

    assign mid = {1'b0, s2_q[QHL]} + {1'b0, s2_q[QLH]};
    assign sum = {s2_q[QHH], s2_q[QLL]} + ((2*W)'(mid) << H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe     <= '0;
            bus.out_prod <= '0;
            bus.out_mode <= '0;
        end else begin
            if (s1_en) vld_pipe[1] <= bus.in_valid;
            if (s2_en) vld_pipe[2] <= vld_pipe[1];
            if (s3_en) begin
                vld_pipe[3] <= vld_pipe[2];
                if (vld_pipe[2]) begin
                    bus.out_prod <= sum;
                    bus.out_mode <= s2_mode;
                end
            end
        end
    end

    // Datapath registers behind the valid flags carry no reset.
    always_ff @(posedge clk) begin
        if (bus.in_valid && s1_en) begin
            a_h     <= bus.in_a;
            b_h     <= bus.in_b;
            s1_mode <= bus.in_mode;
        end
        if (s2_en && vld_pipe[1]) begin
            s2_q    <= q_comb;
            s2_mode <= s1_mode;
        end
    end
endmodule

// File: tb/tb_hslp_mul_pipe.sv
// Randomised bench for hslp_mul_pipe against a queue-based arithmetic model,
// plus literal-value pins for the model and a W=16/TRUNC=0 instance.
module tb_hslp_mul_pipe;
    localparam int T8 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hslp_mul_pipe_if #(.W(8))  b8 ();
    hslp_mul_pipe_if #(.W(16)) b16 ();

    hslp_mul_pipe #(.W(8),  .TRUNC(T8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    hslp_mul_pipe #(.W(16), .TRUNC(0))  dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    typedef struct { logic [15:0] p; logic [3:0] m; } exp_t;
    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          stream = 1'b0;
    int          scnt = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] hold_p;
    logic [3:0]  hold_m;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Row-wise view: each row of x shifted by j, with columns below TRUNC masked.
    function automatic int unsigned qm(input int unsigned x, input int unsigned y, input bit m);
        int unsigned r = 0;
        for (int j = 0; j < 4; j++)
            if (((y >> j) & 1) != 0)
                r += m ? ((x << j) & ~((32'd1 << T8) - 1)) : (x << j);
        return r;
    endfunction

    function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b, input logic [3:0] md);
        int unsigned qv[4];
        for (int k = 0; k < 4; k++) begin
            int unsigned x, y;
            x = (k >= 2) ? int'(a[7:4]) : int'(a[3:0]);
            y = (k % 2 == 1) ? int'(b[7:4]) : int'(b[3:0]);
            qv[k] = qm(x, y, md[k]);
        end
        return 16'(qv[3] * 256 + (qv[2] + qv[1]) * 16 + qv[0]);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
            scnt = 0;
        end else begin
            chk("in_ready", 64'(b8.in_ready), 64'((q.size() < 3) || b8.out_ready));
            if (prev_stall) begin
                chk("stall_valid", 64'(b8.out_valid), 64'd1);
                chk("stall_prod", 64'(b8.out_prod), 64'(hold_p));
                chk("stall_mode", 64'(b8.out_mode), 64'(hold_m));
            end
            if (stream) begin
                if (scnt >= 3) chk("stream_valid", 64'(b8.out_valid), 64'd1);
                scnt++;
            end else scnt = 0;
            if (b8.out_valid && b8.out_ready) begin
                if (q.size() == 0) chk("unexpected_out", 64'(b8.out_valid), 64'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("prod", 64'(b8.out_prod), 64'(e.p));
                    chk("mode", 64'(b8.out_mode), 64'(e.m));
                end
            end
            if (b8.in_valid && b8.in_ready)
                q.push_back('{p: golden(b8.in_a, b8.in_b, b8.in_mode), m: b8.in_mode});
            prev_stall = b8.out_valid && !b8.out_ready;
            hold_p = b8.out_prod;
            hold_m = b8.out_mode;
        end
    end

    task automatic dir8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m,
                        input logic [15:0] exp);
        @(posedge clk); #1;
        b8.in_valid = 1'b1; b8.in_a = a; b8.in_b = b; b8.in_mode = m; b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        @(negedge clk); chk("lat_e1", 64'(b8.out_valid), 64'd0);
        @(negedge clk); chk("lat_e2", 64'(b8.out_valid), 64'd0);
        @(negedge clk); chk("lat_e3", 64'(b8.out_valid), 64'd1);
        chk("dir_prod", 64'(b8.out_prod), 64'(exp));
        chk("dir_mode", 64'(b8.out_mode), 64'(m));
    endtask

    task automatic dir16(input logic [3:0] m, input logic [31:0] exp);
        @(posedge clk); #1;
        b16.in_valid = 1'b1; b16.in_a = 16'hFFFF; b16.in_b = 16'hFFFF; b16.in_mode = m;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("w16_valid", 64'(b16.out_valid), 64'd1);
        chk("w16_prod", 64'(b16.out_prod), 64'(exp));
    endtask

    task automatic drain();
        int guard = 0;
        b8.in_valid = 1'b0;
        b8.out_ready = 1'b1;
        while (q.size() != 0 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        b8.in_valid = 1'b0; b8.in_a = '0; b8.in_b = '0; b8.in_mode = '0; b8.out_ready = 1'b0;
        b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.in_mode = '0; b16.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(b8.out_valid), 64'd0);
        chk("rst_prod", 64'(b8.out_prod), 64'd0);
        chk("rst_mode", 64'(b8.out_mode), 64'd0);
        chk("rst_ready", 64'(b8.in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        dir8(8'hFF, 8'hFF, 4'b0000, 16'hFE01);
        dir8(8'hFF, 8'hFF, 4'b1111, 16'hEAD0);
        dir8(8'hFF, 8'hFF, 4'b0111, 16'hFBD0);
        dir8(8'h00, 8'hFF, 4'b1111, 16'h0000);
        drain();

        // Full-rate streaming: one result per cycle once the pipe has filled.
        for (int n = 0; n < 10000; n++) begin
            @(posedge clk); #1;
            b8.in_valid = 1'b1;
            b8.in_a = 8'($urandom); b8.in_b = 8'($urandom); b8.in_mode = 4'($urandom);
            stream = 1'b1;
        end
        @(posedge clk); #1;
        stream = 1'b0;
        drain();

        // Random valid/backpressure toggling.
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            b8.in_valid = ($urandom_range(0, 9) < 7);
            b8.out_ready = ($urandom_range(0, 9) < 5);
            b8.in_a = 8'($urandom); b8.in_b = 8'($urandom); b8.in_mode = 4'($urandom);
        end
        drain();

        // Fill all three stages under backpressure, then reset mid-flight.
        b8.out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            b8.in_valid = 1'b1;
            b8.in_a = 8'($urandom); b8.in_b = 8'($urandom); b8.in_mode = 4'($urandom);
        end
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        @(negedge clk);
        chk("full_valid", 64'(b8.out_valid), 64'd1);
        chk("full_ready", 64'(b8.in_ready), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(b8.out_valid), 64'd0);
        chk("midrst_prod", 64'(b8.out_prod), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        b8.out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(b8.in_ready), 64'd1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("no_stale", 64'(b8.out_valid), 64'd0);
        end

        dir16(4'b1111, 32'hFFFE0001);
        dir16(4'b0000, 32'hFFFE0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
